spi_master: RTL and testbench

- SPI master: the initiating end of the link served by the existing spi_slave.
- Shifts one WIDTH-bit word out on spi_out while shifting one word in from spi_in; MSB first.
- Generates spi_clk and spi_ss from the system clock through a programmable divider.
- Used to drive external SPI peripherals and to exercise spi_slave in loopback benches.

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_clk_div.sv | 36 +++
 rtl/spi_master.sv | 129 ++++++++++++
 tb/tb_spi_master.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types for the SPI master: transfer FSM states and {CPOL,CPHA} mode codes.
package spi_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    SHIFT = 2'd2,
    TRAIL = 2'd3
  } state_t;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;
endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: tick every clk_div+1 enabled cycles while run is high.
// load restarts the count from div; ena low freezes the counter and suppresses tick.
module spi_clk_div #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 load,
  input  logic                 run,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);
  localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] div_q;

  assign tick = ena && run && (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      div_q <= '0;
    end else if (ena) begin
      if (load) begin
        cnt   <= div;
        div_q <= div;
      end else if (tick) begin
        cnt <= div_q;
      end else if (run) begin
        cnt <= cnt - ONE;
      end
    end
  end
endmodule

// File: rtl/spi_master.sv
// SPI master: one WIDTH-bit full-duplex MSB-first word per start; rx at 1+(2*WIDTH+1)*H cycles.
// ena low freezes all state; hold_ss with start at end of TRAIL chains words under one spi_ss.
module spi_master
  import spi_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 start,
  input  logic                 hold_ss,
  input  logic [DIV_WIDTH-1:0] clk_div,
  input  logic                 spi_clk_polarity,
  input  logic                 spi_clk_phase,
  input  logic [WIDTH-1:0]     bus_in,
  output logic [WIDTH-1:0]     bus_out,
  output logic                 tx,
  output logic                 rx,
  output logic                 busy,
  output logic                 spi_clk,
  output logic                 spi_ss,
  output logic                 spi_out,
  input  logic                 spi_in
);
  localparam int EW = $clog2(2 * WIDTH + 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * WIDTH - 1);
  localparam logic [EW-1:0] EDGE_ONE  = EW'(1);

  state_t           state;
  state_t           state_nxt;
  logic             tick;
  logic             accept;
  logic             done;
  logic             edge_evt;
  logic             leading;
  logic             shift_now;
  logic             sample_now;
  logic [EW-1:0]    edge_cnt;
  logic             cpha_q;
  logic [WIDTH-1:0] tx_sr;
  logic [WIDTH-1:0] rx_sr;

  spi_clk_div #(.DIV_WIDTH(DIV_WIDTH)) u_div (
    .clk  (clk),
    .rst  (rst),
    .ena  (ena),
    .load (accept),
    .run  (busy),
    .div  (clk_div),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (ena) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = LEAD;
      LEAD:  if (tick) state_nxt = SHIFT;
      SHIFT: if (tick && edge_cnt == LAST_EDGE) state_nxt = TRAIL;
      TRAIL: if (tick) state_nxt = (hold_ss && start) ? LEAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // edge_cnt counts spi_clk edges already emitted, so an even count means the next edge is leading
  always_comb begin
    busy       = (state != IDLE);
    done       = (state == TRAIL) && tick;
    accept     = ((state == IDLE) && start) || (done && hold_ss && start);
    edge_evt   = tick && ((state == LEAD) || (state == SHIFT));
    leading    = !edge_cnt[0];
    shift_now  = edge_evt && (leading == cpha_q);
    sample_now = edge_evt && (leading != cpha_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spi_ss   <= 1'b1;
      spi_clk  <= spi_clk_polarity;
      spi_out  <= 1'b0;
      bus_out  <= '0;
      tx       <= 1'b0;
      rx       <= 1'b0;
      edge_cnt <= '0;
      cpha_q   <= 1'b0;
      tx_sr    <= '0;
      rx_sr    <= '0;
    end else if (ena) begin
      tx <= accept;
      rx <= done;
      if (done) bus_out <= rx_sr;
      if (accept) begin
        cpha_q   <= spi_clk_phase;
        spi_ss   <= 1'b0;
        spi_clk  <= spi_clk_polarity;
        edge_cnt <= '0;
        rx_sr    <= '0;
        // CPHA=0 must present the MSB before the first leading edge
        if (spi_clk_phase) begin
          tx_sr <= bus_in;
        end else begin
          tx_sr   <= {bus_in[WIDTH-2:0], 1'b0};
          spi_out <= bus_in[WIDTH-1];
        end
      end else begin
        if (done) spi_ss <= 1'b1;
        if (!busy) spi_clk <= spi_clk_polarity;
        if (edge_evt) begin
          spi_clk  <= ~spi_clk;
          edge_cnt <= edge_cnt + EDGE_ONE;
        end
        if (shift_now) begin
          spi_out <= tx_sr[WIDTH-1];
          tx_sr   <= {tx_sr[WIDTH-2:0], 1'b0};
        end
        if (sample_now) rx_sr <= {rx_sr[WIDTH-2:0], spi_in};
      end
    end
  end
endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: directed and randomized transfers against a behavioural SPI slave.
module tb_spi_master;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst, ena, start, hold_ss, spi_clk_polarity, spi_clk_phase;
  logic [7:0] clk_div, bus_in, bus_out;
  logic       tx, rx, busy, spi_clk, spi_ss, spi_out, spi_in;
  logic       loop_en = 1'b1;
  logic       miso = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  assign spi_in = loop_en ? spi_out : miso;
  always #5 clk = ~clk;

  spi_master #(.WIDTH(W), .DIV_WIDTH(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .ena              (ena),
    .start            (start),
    .hold_ss          (hold_ss),
    .clk_div          (clk_div),
    .spi_clk_polarity (spi_clk_polarity),
    .spi_clk_phase    (spi_clk_phase),
    .bus_in           (bus_in),
    .bus_out          (bus_out),
    .tx               (tx),
    .rx               (rx),
    .busy             (busy),
    .spi_clk          (spi_clk),
    .spi_ss           (spi_ss),
    .spi_out          (spi_out),
    .spi_in           (spi_in)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Behavioural slave: reacts to spi_clk edges seen just after each system clock edge
  logic       s_cpol = 1'b0, s_cpha = 1'b0, s_prev = 1'b0;
  logic [7:0] s_data = 8'h00, s_sr = 8'h00, s_rx = 8'h00;

  always @(posedge clk) begin
    #1;
    if (spi_ss === 1'b1) begin
      s_sr = s_data;
      miso = s_cpha ? 1'b0 : s_data[7];
    end else if (spi_ss === 1'b0 && spi_clk !== s_prev) begin
      if ((spi_clk != s_cpol) != s_cpha) begin
        s_rx = {s_rx[6:0], spi_out};
      end else if (s_cpha) begin
        miso = s_sr[7];
        s_sr = {s_sr[6:0], 1'b0};
      end else begin
        s_sr = {s_sr[6:0], 1'b0};
        miso = s_sr[7];
      end
    end
    s_prev = spi_clk;
  end

  // One transfer; expectations come from the timing rules: rx at 1+(2W+1)*H plus frozen cycles
  task automatic xfer(input logic cpol, input logic cpha, input int div, input logic [7:0] data,
                      input logic [7:0] sdata, input logic lp, input int gap_at, input int gap_len);
    int   exp_rx, rx_cyc, tx_cyc, tx_cnt, ss_low, toggles;
    logic prev_clk, frz_clk, frz_ss, frz_out, frz_ok;
    exp_rx = 1 + (2 * W + 1) * (div + 1) + gap_len;
    rx_cyc = 0; tx_cyc = 0; tx_cnt = 0; ss_low = 0; toggles = 0;
    frz_ok = 1'b1; frz_clk = 1'b0; frz_ss = 1'b0; frz_out = 1'b0;
    @(negedge clk);
    spi_clk_polarity = cpol; spi_clk_phase = cpha; clk_div = 8'(div); bus_in = data;
    loop_en = lp; s_cpol = cpol; s_cpha = cpha; s_data = sdata; s_sr = sdata;
    s_rx = 8'h00; s_prev = cpol; miso = cpha ? 1'b0 : sdata[7];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    prev_clk = spi_clk;
    for (int n = 1; n <= exp_rx + 40; n++) begin
      if (n > 1) begin
        @(posedge clk); #1;
      end
      if (n == 1) begin
        check_eq("busy_c1", 32'(busy), 1);
        check_eq("ss_c1", 32'(spi_ss), 0);
        check_eq("clk_idle_before", 32'(spi_clk), 32'(cpol));
        if (!cpha) check_eq("msb_c1", 32'(spi_out), 32'(data[7]));
      end
      if (tx) begin
        tx_cnt++;
        if (tx_cyc == 0) tx_cyc = n;
      end
      if (!spi_ss) ss_low++;
      if (spi_clk !== prev_clk) toggles++;
      prev_clk = spi_clk;
      if (gap_len > 0 && n > gap_at && n <= gap_at + gap_len &&
          (spi_clk !== frz_clk || spi_ss !== frz_ss || spi_out !== frz_out)) frz_ok = 1'b0;
      if (gap_len > 0 && n == gap_at) begin
        frz_clk = spi_clk; frz_ss = spi_ss; frz_out = spi_out;
        ena = 1'b0;
      end
      if (gap_len > 0 && n == gap_at + gap_len) ena = 1'b1;
      if (rx) begin
        rx_cyc = n;
        break;
      end
    end
    ena = 1'b1;
    check_eq("tx_cycle", tx_cyc, 1);
    check_eq("tx_count", tx_cnt, 1);
    check_eq("rx_cycle", rx_cyc, exp_rx);
    check_eq("bus_out", 32'(bus_out), lp ? 32'(data) : 32'(sdata));
    check_eq("ss_low_cycles", ss_low, exp_rx - 1);
    check_eq("clk_toggles", toggles, 2 * W);
    check_eq("clk_idle_after", 32'(spi_clk), 32'(cpol));
    check_eq("ss_released", 32'(spi_ss), 1);
    check_eq("busy_end", 32'(busy), 0);
    if (!lp) check_eq("slave_rx", 32'(s_rx), 32'(data));
    if (gap_len > 0) check_eq("frozen", 32'(frz_ok), 1);
  endtask

  initial begin
    int r1, r2, tx_seen, ss_high, rx_seen;
    logic [7:0] b1, b2;
    logic busy_r2;
    rst = 1'b1; ena = 1'b1; start = 1'b0; hold_ss = 1'b0;
    spi_clk_polarity = 1'b0; spi_clk_phase = 1'b0; clk_div = 8'd0; bus_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ss", 32'(spi_ss), 1);
    check_eq("rst_clk", 32'(spi_clk), 0);
    check_eq("rst_out", 32'(spi_out), 0);
    check_eq("rst_bus_out", 32'(bus_out), 0);
    check_eq("rst_tx", 32'(tx), 0);
    check_eq("rst_rx", 32'(rx), 0);
    check_eq("rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;

    xfer(1'b0, 1'b0, 4, 8'hA5, 8'h00, 1'b1, 0, 0);
    xfer(1'b1, 1'b1, 2, 8'h96, 8'h3C, 1'b0, 0, 0);
    xfer(1'b0, 1'b1, 0, 8'hFF, 8'h5A, 1'b0, 0, 0);
    xfer(1'b0, 1'b0, 4, 8'hC3, 8'h00, 1'b1, 30, 10);

    // Chained words: spi_ss must stay low across the word boundary
    @(negedge clk);
    spi_clk_polarity = 1'b0; spi_clk_phase = 1'b0; clk_div = 8'd4; bus_in = 8'h01;
    loop_en = 1'b1; hold_ss = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    bus_in = 8'h02;
    r1 = 0; r2 = 0; tx_seen = 0; ss_high = 0; b1 = 8'h00; b2 = 8'h00; busy_r2 = 1'b1;
    for (int n = 1; n <= 260; n++) begin
      if (n > 1) begin
        @(posedge clk); #1;
      end
      if (tx) tx_seen++;
      if (rx && r1 == 0) begin
        r1 = n; b1 = bus_out;
        start = 1'b0; hold_ss = 1'b0;
      end else if (rx) begin
        r2 = n; b2 = bus_out; busy_r2 = busy;
        break;
      end
      if (spi_ss) ss_high++;
    end
    start = 1'b0; hold_ss = 1'b0;
    check_eq("chain_rx1_cycle", r1, 86);
    check_eq("chain_word1", 32'(b1), 32'h01);
    check_eq("chain_gap", r2 - r1, 85);
    check_eq("chain_word2", 32'(b2), 32'h02);
    check_eq("chain_ss_held", ss_high, 0);
    check_eq("chain_tx_count", tx_seen, 2);
    check_eq("chain_busy_end", 32'(busy_r2), 0);

    // Reset at cycle 40 of a transfer aborts it without an rx pulse
    @(negedge clk);
    spi_clk_phase = 1'b0; clk_div = 8'd4; bus_in = 8'h5A; loop_en = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 2; n <= 40; n++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_ss", 32'(spi_ss), 1);
    check_eq("abort_busy", 32'(busy), 0);
    check_eq("abort_bus_out", 32'(bus_out), 0);
    check_eq("abort_rx", 32'(rx), 0);
    rst = 1'b0;
    rx_seen = 0;
    for (int n = 0; n < 120; n++) begin
      @(posedge clk); #1;
      if (rx) rx_seen++;
    end
    check_eq("abort_no_rx", rx_seen, 0);
    xfer(1'b0, 1'b0, 1, 8'h3E, 8'h00, 1'b1, 0, 0);

    for (int i = 0; i < 10; i++) begin
      int div, gl, ga;
      div = int'($urandom_range(6, 0));
      gl  = ($urandom_range(1, 0) == 1) ? int'($urandom_range(12, 1)) : 0;
      ga  = int'($urandom_range(16 * (div + 1), div + 3));
      xfer(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), div, 8'($urandom),
           8'($urandom), 1'($urandom_range(1, 0)), ga, gl);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
